// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding and default sizing.
package shared_reg_arbiter_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    ACK   = 2'b10
  } state_t;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping past N-1.
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] winner_idx
);

  logic found;
  int   j;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    j          = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j[PW-1:0]]) begin
        found              = 1'b1;
        winner[j[PW-1:0]]  = 1'b1;
        winner_idx         = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// N requesters share one W-bit register; round-robin arbitration, one write per three cycles.
//   state | meaning
//   IDLE  | no transaction; sample req and pick a winner
//   GRANT | gnt[winner] high; write if winner still requests, else abort
//   ACK   | one-cycle ack[winner] pulse after the write
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic           busy
);

  localparam int PW = $clog2(N);

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] win_idx, win_idx_nxt;
  logic [PW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic [N-1:0]  gnt_nxt, ack_nxt;
  logic [W-1:0]  q_nxt;
  logic          q_valid_nxt;

  rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .req        (req),
    .ptr        (ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      win_idx <= '0;
      gnt     <= '0;
      ack     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win_idx <= win_idx_nxt;
      gnt     <= gnt_nxt;
      ack     <= ack_nxt;
      q       <= q_nxt;
      q_valid <= q_valid_nxt;
    end
  end

  // The winner is latched in IDLE so later req/wdata changes cannot retarget the transaction.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_idx_nxt = win_idx;
    gnt_nxt     = '0;
    ack_nxt     = '0;
    q_nxt       = q;
    q_valid_nxt = q_valid;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt     = pick_onehot;
          win_idx_nxt = pick_idx;
          state_nxt   = GRANT;
        end
      end
      GRANT: begin
        if (req[win_idx]) begin
          q_nxt       = wdata[win_idx*W +: W];
          q_valid_nxt = 1'b1;
          ptr_nxt     = (win_idx == PW'(N-1)) ? '0 : win_idx + 1'b1;
          ack_nxt     = gnt;
          state_nxt   = ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
